// File: rtl/irq_ctrl.sv
// irq_ctrl: 8-source fixed-priority interrupt controller.
// Rising edges on irq_src latch into pending; the lowest-index unmasked
// pending source is presented to the CPU, acknowledged, then retired by eoi.
module irq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irq_src,
    input  logic       mask_we,
    input  logic [7:0] mask_wdata,
    input  logic       INTA_irq,
    input  logic       eoi,
    output logic       INT_irq,
    output logic [2:0] irq_id,
    output logic [7:0] pending,
    output logic [7:0] in_service,
    output logic [7:0] mask,
    output logic [7:0] ack_cnt,
    output logic [1:0] st
);

    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_ASSERT  = 2'b01;
    localparam logic [1:0] S_SERVICE = 2'b10;

    logic [1:0] state_reg, state_next;
    logic [7:0] src_q_reg;
    logic [7:0] pending_reg, pending_next;
    logic [7:0] mask_reg, mask_next;
    logic [7:0] in_service_reg, in_service_next;
    logic [7:0] ack_cnt_reg, ack_cnt_next;
    logic       int_reg, int_next;
    logic [2:0] irq_id_reg, irq_id_next;

    logic [7:0] rise;
    logic [7:0] eligible;
    logic [2:0] winner;
    logic [7:0] id_onehot;
    logic [7:0] pend_clear;
    logic       withdraw;

    assign rise     = irq_src & ~src_q_reg;
    assign eligible = pending_reg & ~mask_reg;
    // A mask write that covers the currently requested source pulls the request back.
    assign withdraw = mask_we & mask_wdata[irq_id_reg];

    // One-hot decode of the current request ID.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_onehot
            assign id_onehot[gi] = (irq_id_reg == 3'(gi));
        end
    endgenerate

    // Fixed priority: lowest-index eligible source wins.
    always_comb begin
        winner = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (eligible[i]) winner = 3'(i);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic; an acknowledge takes precedence over a withdrawing mask write.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (eligible != 8'd0) state_next = S_ASSERT;
            S_ASSERT: begin
                if (INTA_irq)      state_next = S_SERVICE;
                else if (withdraw) state_next = S_IDLE;
            end
            S_SERVICE: if (eoi) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and bookkeeping state.
    always_comb begin
        int_next        = int_reg;
        irq_id_next     = irq_id_reg;
        in_service_next = in_service_reg;
        ack_cnt_next    = ack_cnt_reg;
        pend_clear      = 8'd0;
        case (state_reg)
            S_IDLE: begin
                if (eligible != 8'd0) begin
                    int_next    = 1'b1;
                    irq_id_next = winner;
                end else begin
                    int_next = 1'b0;
                end
            end
            S_ASSERT: begin
                if (INTA_irq) begin
                    pend_clear      = id_onehot;
                    in_service_next = id_onehot;
                    int_next        = 1'b0;
                    ack_cnt_next    = ack_cnt_reg + 8'd1;
                end else if (withdraw) begin
                    int_next = 1'b0;
                end
            end
            S_SERVICE: begin
                int_next = 1'b0;
                if (eoi) in_service_next = 8'd0;
            end
            default: begin
                int_next = 1'b0;
            end
        endcase
        // A fresh edge outranks the acknowledge clear on the same bit.
        pending_next = (pending_reg & ~pend_clear) | rise;
        mask_next    = mask_we ? mask_wdata : mask_reg;
    end

    // Datapath registers; reset leaves everything masked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q_reg      <= 8'd0;
            pending_reg    <= 8'd0;
            mask_reg       <= 8'hFF;
            in_service_reg <= 8'd0;
            ack_cnt_reg    <= 8'd0;
            int_reg        <= 1'b0;
            irq_id_reg     <= 3'd0;
        end else begin
            src_q_reg      <= irq_src;
            pending_reg    <= pending_next;
            mask_reg       <= mask_next;
            in_service_reg <= in_service_next;
            ack_cnt_reg    <= ack_cnt_next;
            int_reg        <= int_next;
            irq_id_reg     <= irq_id_next;
        end
    end

    assign INT_irq    = int_reg;
    assign irq_id     = irq_id_reg;
    assign pending    = pending_reg;
    assign in_service = in_service_reg;
    assign mask       = mask_reg;
    assign ack_cnt    = ack_cnt_reg;
    assign st         = state_reg;

endmodule
